// File: rtl/fifo_read_ctrl_if.sv
// ----------------------------------------------------------------------------
// fifo_read_ctrl_if
//   Bundle of every non-clock signal of fifo_read_ctrl: burst command,
//   status, FIFO read port and the outgoing valid/ready stream.
//   slave  : view used by fifo_read_ctrl itself
//   master : view used by whatever drives commands, models the FIFO and
//            consumes the stream
// Parameters
//   FIFO_WIDTH  data word width (FIFO data_out and stream data)
//   LEN_W       burst length width
// Signals
//   start/len          burst command (len sampled with an accepted start)
//   busy/done          status; done is a 1-cycle completion pulse
//   fifo_rd_en         FIFO read enable
//   fifo_data_out      FIFO read data, valid 1 cycle after fifo_rd_en
//   fifo_empty         FIFO empty flag
//   fifo_underflow     FIFO read-on-empty flag
//   m_valid/m_ready    stream handshake
//   m_data/m_last      stream payload, m_last marks the final burst word
//   err_underflow      sticky underflow error
// ----------------------------------------------------------------------------
interface fifo_read_ctrl_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int LEN_W      = 8
);
  logic                  start;
  logic [LEN_W-1:0]      len;
  logic                  busy;
  logic                  done;
  logic                  fifo_rd_en;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic                  m_valid;
  logic                  m_ready;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  err_underflow;

  modport slave (
    input  start, len, fifo_data_out, fifo_empty, fifo_underflow, m_ready,
    output busy, done, fifo_rd_en, m_valid, m_data, m_last, err_underflow
  );

  modport master (
    output start, len, fifo_data_out, fifo_empty, fifo_underflow, m_ready,
    input  busy, done, fifo_rd_en, m_valid, m_data, m_last, err_underflow
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_read_ctrl
//   Read-side master for a synchronous FIFO. Accepts a burst command
//   (start + len) while idle, pops exactly len words from the FIFO and
//   forwards them on a valid/ready stream through a 2-entry skid buffer.
//   A FIFO underflow sets a sticky error flag; the returned word is still
//   delivered.
// Ports
//   clk   single clock, all logic on posedge
//   rst   synchronous active-high reset
//   bus   fifo_read_ctrl_if.slave (command, status, FIFO read port, stream)
//   stall_cnt, word_cnt  (only with FIFO_RD_STATS_EN) saturating counters of
//                        back-pressured cycles and of delivered words
// Build option
//   FIFO_RD_STATS_EN  when defined, adds the stall_cnt/word_cnt outputs.
// ----------------------------------------------------------------------------
module fifo_read_ctrl #(
  parameter int FIFO_WIDTH = 16,
  parameter int LEN_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  fifo_read_ctrl_if.slave    bus
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        word_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t                state, state_nxt;
  logic [LEN_W-1:0]      len_q;       // burst length latched at accept
  logic [LEN_W-1:0]      issued;      // rd_en pulses issued this burst
  logic [LEN_W-1:0]      delivered;   // stream pops this burst
  logic [1:0]            occ;         // skid buffer occupancy (0..2)
  logic                  inflight;    // word returning from FIFO this cycle
  logic [FIFO_WIDTH-1:0] buf0, buf1;  // buf0 is the head
  logic                  err_q;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  rd_en;
  logic [2:0]            pending;

  assign accept = (state == S_IDLE) & bus.start;
  assign push   = inflight;
  assign pop    = (occ != 2'd0) & bus.m_ready;

  // Words that will occupy the buffer after this edge if no new read is
  // issued. Reading only when this is below 2 keeps occ from ever exceeding
  // 2 while still allowing a read in the same cycle as a pop, which is what
  // sustains one word per cycle with m_ready held high.
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  assign rd_en = (state == S_RUN) & ~bus.fifo_empty & (issued < len_q) &
                 (pending < 3'd2);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = (bus.len != '0) ? S_RUN : S_DONE;
      S_RUN:   if (issued == len_q) state_nxt = S_DRAIN;
      S_DRAIN: if ((occ == 2'd0) && !inflight) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Burst counters, return pipeline, sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      issued    <= '0;
      delivered <= '0;
      inflight  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (accept) begin
        len_q     <= bus.len;
        issued    <= '0;
        delivered <= '0;
      end else begin
        if (rd_en) issued    <= issued + LEN_ONE;
        if (pop)   delivered <= delivered + LEN_ONE;
      end
      // An underflow in the same cycle as an accepted start is still
      // recorded: the event is more recent than the clear.
      if (bus.fifo_underflow) err_q <= 1'b1;
      else if (accept)        err_q <= 1'b0;
    end
  end

  // Skid buffer: 2 entries, FIFO order, head in buf0. Reset discards any
  // buffered words (the returning in-flight word is dropped with inflight).
  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= bus.fifo_data_out;
          else             buf1 <= bus.fifo_data_out;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word goes behind whatever remains.
          if (occ == 2'd1) begin
            buf0 <= bus.fifo_data_out;
          end else begin
            buf0 <= buf1;
            buf1 <= bus.fifo_data_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy          = (state == S_RUN) | (state == S_DRAIN);
  assign bus.done          = (state == S_DONE);
  assign bus.fifo_rd_en    = rd_en;
  assign bus.m_valid       = (occ != 2'd0);
  assign bus.m_data        = buf0;
  assign bus.m_last        = (occ != 2'd0) & (delivered == (len_q - LEN_ONE));
  assign bus.err_underflow = err_q;

`ifdef FIFO_RD_STATS_EN
  // Cleared only by reset; both hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      word_cnt  <= '0;
    end else begin
      if ((occ != 2'd0) && !bus.m_ready && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (pop && (word_cnt != 32'hFFFF_FFFF))
        word_cnt <= word_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;
  localparam int W     = 16;
  localparam int LW    = 8;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_read_ctrl_if #(.FIFO_WIDTH(W), .LEN_W(LW)) bus();

`ifdef FIFO_RD_STATS_EN
  logic [31:0] stall_cnt, word_cnt;
`endif

  fifo_read_ctrl #(.FIFO_WIDTH(W), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FIFO_RD_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .word_cnt  (word_cnt)
`endif
  );

  // ---------------- FIFO model ----------------
  logic [W-1:0] mem [DEPTH];
  int           wr_ptr = 0;     // written only by the stimulus thread
  int           rd_ptr = 0;     // written only by the FIFO read process
  logic         uf_force = 1'b0;
  logic [W-1:0] exp_q [$];      // every pushed word, in order

  assign bus.fifo_empty     = (wr_ptr == rd_ptr);
  assign bus.fifo_underflow = uf_force;

  always @(posedge clk) begin
    if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
      bus.fifo_data_out <= mem[rd_ptr % DEPTH];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic push_word(input logic [W-1:0] d);
    mem[wr_ptr % DEPTH] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  // ---------------- stream monitor ----------------
  int           cyc = 0;
  logic [W-1:0] got_d [$];
  logic         got_l [$];
  int           got_c [$];
  int           rd_cnt = 0, done_cnt = 0, done_cyc = 0;
  int           outst = 0, occ_viol = 0, stab_viol = 0;
  int           pops_rst = 0, stalls_rst = 0;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_d = '0;
  logic         hold_l = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      outst = 0; hold_v = 1'b0; pops_rst = 0; stalls_rst = 0;
    end else begin
      if (hold_v && (!bus.m_valid || bus.m_data !== hold_d || bus.m_last !== hold_l))
        stab_viol++;
      hold_v = bus.m_valid && !bus.m_ready;
      hold_d = bus.m_data;
      hold_l = bus.m_last;
      if (bus.fifo_rd_en) begin rd_cnt++; outst++; end
      if (bus.m_valid && bus.m_ready) begin
        got_d.push_back(bus.m_data);
        got_l.push_back(bus.m_last);
        got_c.push_back(cyc);
        outst--;
        pops_rst++;
      end
      if (bus.m_valid && !bus.m_ready) stalls_rst++;
      if (outst > 2) occ_viol++;
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_ready(input int mode, input int i);
    case (mode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = ((i % 2) == 0);
      2:       bus.m_ready = 1'($urandom_range(0, 1));
      default: bus.m_ready = 1'b0;
    endcase
  endtask

  // Entered and left at posedge+1.
  task automatic start_burst(input int len);
    bus.start = 1'b1;
    bus.len   = LW'(len);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Runs until the done pulse is seen (then steps past DONE into IDLE).
  task automatic wait_done(input int mode, input int budget, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < budget) begin
      set_ready(mode, i);
      @(negedge clk);
      if (bus.done) ok = 1'b1;
      @(posedge clk); #1;
      i++;
    end
  endtask

  // Compares the words delivered since index b0 against the next len
  // pushed words, plus read count, done count and the idle state.
  task automatic check_burst(input string nm, input int len, input int b0,
                             input int rd0, input int dn0);
    int n;
    logic [W-1:0] e;
    n = got_d.size() - b0;
    chk({nm, " words"}, 64'(n), 64'(len));
    for (int k = 0; k < len; k++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      if (k < n) begin
        chk({nm, " data"}, 64'(got_d[b0+k]), 64'(e));
        chk({nm, " last"}, 64'(got_l[b0+k]), 64'(k == len - 1));
      end
    end
    chk({nm, " rd_en pulses"}, 64'(rd_cnt - rd0), 64'(len));
    chk({nm, " done pulses"}, 64'(done_cnt - dn0), 64'd1);
    chk({nm, " busy idle"}, 64'(bus.busy), 64'd0);
  endtask

  typedef struct {
    int len;
    int preload;
    int rmode;
    int exp_rd;
    int exp_done;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    bit   ok;
    int   b0, rd0, dn0, n, len, pre;

    vt[0] = '{len: 2,   preload: 2,   rmode: 0, exp_rd: 2,   exp_done: 1};
    vt[1] = '{len: 0,   preload: 0,   rmode: 0, exp_rd: 0,   exp_done: 1};
    vt[2] = '{len: 6,   preload: 6,   rmode: 1, exp_rd: 6,   exp_done: 1};
    vt[3] = '{len: 1,   preload: 1,   rmode: 0, exp_rd: 1,   exp_done: 1};
    vt[4] = '{len: 3,   preload: 5,   rmode: 2, exp_rd: 3,   exp_done: 1};
    vt[5] = '{len: 255, preload: 253, rmode: 2, exp_rd: 255, exp_done: 1};

    bus.start = 1'b0;
    bus.len = '0;
    bus.m_ready = 1'b0;

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy",  64'(bus.busy), 0);
    chk("rst done",  64'(bus.done), 0);
    chk("rst rd_en", 64'(bus.fifo_rd_en), 0);
    chk("rst valid", 64'(bus.m_valid), 0);
    chk("rst data",  64'(bus.m_data), 0);
    chk("rst last",  64'(bus.m_last), 0);
    chk("rst err",   64'(bus.err_underflow), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- A..D at full rate, first-valid latency ----
    push_word(16'hA0A0); push_word(16'hB1B1); push_word(16'hC2C2); push_word(16'hD3D3);
    bus.m_ready = 1'b1;
    b0 = got_d.size(); rd0 = rd_cnt; dn0 = done_cnt;
    start_burst(4);
    n = 0; ok = 1'b0;
    while (!ok && n < 10) begin
      @(negedge clk);
      n++;
      if (bus.m_valid) ok = 1'b1;
      @(posedge clk); #1;
    end
    chk("abcd first valid negedge", 64'(n), 64'd3);
    wait_done(0, 50, ok);
    chk("abcd timeout", 64'(ok), 1);
    if (got_d.size() >= b0 + 4) begin
      chk("abcd consecutive", 64'(got_c[b0+3] - got_c[b0]), 64'd3);
      chk("abcd done follows D", 64'((done_cyc - got_c[b0+3] >= 1) && (done_cyc - got_c[b0+3] <= 2)), 1);
    end
    check_burst("abcd", 4, b0, rd0, dn0);

    // ---- table-driven bursts ----
    for (int v = 0; v < 6; v++) begin
      for (int p = 0; p < vt[v].preload; p++) push_word(W'($urandom));
      b0 = got_d.size(); rd0 = rd_cnt; dn0 = done_cnt;
      start_burst(vt[v].len);
      wait_done(vt[v].rmode, 2000, ok);
      chk($sformatf("vec%0d timeout", v), 64'(ok), 1);
      chk($sformatf("vec%0d rd", v), 64'(rd_cnt - rd0), 64'(vt[v].exp_rd));
      chk($sformatf("vec%0d done", v), 64'(done_cnt - dn0), 64'(vt[v].exp_done));
      check_burst($sformatf("vec%0d", v), vt[v].len, b0, rd0, dn0);
    end

    // ---- randomized bursts, FIFO filled partly before and partly during ----
    for (int r = 0; r < 20; r++) begin
      len = $urandom_range(0, 12);
      pre = $urandom_range(0, len);
      for (int p = 0; p < pre; p++) push_word(W'($urandom));
      b0 = got_d.size(); rd0 = rd_cnt; dn0 = done_cnt;
      start_burst(len);
      fork
        wait_done(2, 400, ok);
        begin
          repeat ($urandom_range(1, 8)) @(posedge clk);
          #2;
          for (int p = pre; p < len; p++) push_word(W'($urandom));
        end
      join
      chk($sformatf("rnd%0d timeout", r), 64'(ok), 1);
      check_burst($sformatf("rnd%0d", r), len, b0, rd0, dn0);
    end

    // ---- empty FIFO mid-burst stalls in RUN ----
    push_word(16'h1111); push_word(16'h2222);
    b0 = got_d.size(); rd0 = rd_cnt; dn0 = done_cnt;
    bus.m_ready = 1'b1;
    start_burst(5);
    repeat (12) begin @(posedge clk); #1; end
    chk("stall words so far", 64'(got_d.size() - b0), 64'd2);
    chk("stall busy", 64'(bus.busy), 1);
    chk("stall no done", 64'(done_cnt - dn0), 0);
    push_word(16'h3333); push_word(16'h4444); push_word(16'h5555);
    wait_done(0, 50, ok);
    chk("stall timeout", 64'(ok), 1);
    check_burst("stall", 5, b0, rd0, dn0);

    // ---- underflow flag ----
    for (int p = 0; p < 4; p++) push_word(W'($urandom));
    b0 = got_d.size(); rd0 = rd_cnt; dn0 = done_cnt;
    start_burst(4);
    @(posedge clk); #1;
    uf_force = 1'b1;
    @(posedge clk); #1;
    uf_force = 1'b0;
    @(negedge clk);
    chk("uf err set", 64'(bus.err_underflow), 1);
    @(posedge clk); #1;
    wait_done(0, 50, ok);
    chk("uf timeout", 64'(ok), 1);
    chk("uf err sticky", 64'(bus.err_underflow), 1);
    check_burst("uf", 4, b0, rd0, dn0);
    b0 = got_d.size(); rd0 = rd_cnt; dn0 = done_cnt;
    start_burst(0);
    chk("uf err cleared by start", 64'(bus.err_underflow), 0);
    wait_done(0, 10, ok);
    chk("len0 timeout", 64'(ok), 1);
    check_burst("len0", 0, b0, rd0, dn0);

    // ---- reset mid-burst with two words buffered ----
    push_word(16'h7001); push_word(16'h7002); push_word(16'h7003);
    rd0 = rd_cnt; dn0 = done_cnt;
    bus.m_ready = 1'b0;
    start_burst(6);
    repeat (4) begin @(posedge clk); #1; end
    chk("midrst reads", 64'(rd_cnt - rd0), 64'd2);
    chk("midrst buffered valid", 64'(bus.m_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst valid", 64'(bus.m_valid), 0);
    chk("midrst busy", 64'(bus.busy), 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst no done", 64'(done_cnt - dn0), 0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    b0 = got_d.size(); rd0 = rd_cnt; dn0 = done_cnt;
    start_burst(1);
    wait_done(0, 20, ok);
    chk("postrst timeout", 64'(ok), 1);
    check_burst("postrst", 1, b0, rd0, dn0);

`ifdef FIFO_RD_STATS_EN
    chk("stats word_cnt", 64'(word_cnt), 64'(pops_rst));
    chk("stats stall_cnt", 64'(stall_cnt), 64'(stalls_rst));
`endif

    chk("hold stable while stalled", 64'(stab_viol), 0);
    chk("buffer never over 2", 64'(occ_viol), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
